// File: rtl/multi_wave_display_pkg.sv
// multi_wave_display_pkg
// Shared constants for the overlaid waveform renderer: channel limits,
// pipeline depth, default window origin and default per-channel colours,
// plus the unsigned span test used by the per-channel comparators.
// No ports; imported by multi_wave_display and wave_channel_cmp.
package multi_wave_display_pkg;

  localparam int NUM_CH_MAX  = 4;
  localparam int PIPE_LAT    = 2;
  localparam int DEF_X_START = 256;

  localparam logic [23:0] COLOR_CH0 = 24'hFFFF00;
  localparam logic [23:0] COLOR_CH1 = 24'h00FFFF;
  localparam logic [23:0] COLOR_CH2 = 24'hFF00FF;
  localparam logic [23:0] COLOR_CH3 = 24'h00FF00;

  // Channel 0 occupies the low 24 bits.
  localparam logic [24*NUM_CH_MAX-1:0] DEF_CH_COLORS =
    {COLOR_CH3, COLOR_CH2, COLOR_CH1, COLOR_CH0};

  // True when v lies between a and b inclusive, whichever order a/b come in.
  function automatic logic span_hit(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] v);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/wave_channel_cmp.sv
// wave_channel_cmp
// One channel of the waveform renderer. Keeps the previous sample so a
// vertical segment can be drawn between consecutive samples, and decides
// whether the current pixel row is lit for this channel.
// Ports:
//   clk, reset  - pixel clock, synchronous active-high reset
//   load_prev   - sample index advanced (or row start); capture a new prev
//   first       - first column of the window; prev takes cur (dot only)
//   cur         - RAM sample for the pixel in stage 1
//   yv          - halved pixel row for the pixel in stage 1
//   gate        - pixel is valid and inside the window
//   connect_en  - 1 draws segments, 0 draws single dots
//   lit         - this channel lights the pixel (combinational)
module wave_channel_cmp
  import multi_wave_display_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_prev,
  input  logic                first,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [SAMPLE_W-1:0] yv,
  input  logic                gate,
  input  logic                connect_en,
  output logic                lit
);

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [SAMPLE_W-1:0] last_q, last_d;

  // last_q remembers the sample seen one pixel earlier; when the index
  // advances it becomes the segment's start point. The freshly chosen prev
  // is used in the same cycle, so the segment appears on the new sample's
  // first column.
  always_comb begin
    last_d = cur;
    prev_d = prev_q;
    if (load_prev) begin
      prev_d = first ? cur : last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      last_q <= '0;
    end else begin
      prev_q <= prev_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    lit = 1'b0;
    if (gate) begin
      if (connect_en) begin
        lit = span_hit(8'(prev_d), 8'(cur), 8'(yv));
      end else begin
        lit = (yv == cur);
      end
    end
  end

endmodule

// File: rtl/multi_wave_display.sv
// multi_wave_display
// Overlays NUM_CH audio waveforms in a fixed window of the screen. The
// display half of the double-buffered sample RAMs is latched at frame start
// so the picture never tears; a 2-cycle pipeline absorbs the RAM latency.
// Ports:
//   clk, reset      - pixel clock, synchronous active-high reset
//   x, y, valid     - pixel position from the timing generator
//   read_value      - per-channel RAM data, one cycle after read_address
//   read_index      - buffer half the producer is currently writing
//   connect_en      - 1 connected lines, 0 dots
//   read_address    - shared RAM address {display half, sample index}
//   valid_pixel     - some waveform is lit at the output pixel
//   r, g, b         - output colour, 2 cycles after x/y/valid
module multi_wave_display
  import multi_wave_display_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 9,
  parameter int X_START  = DEF_X_START,
  parameter logic [24*NUM_CH_MAX-1:0] CH_COLORS = DEF_CH_COLORS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x,
  input  logic [9:0]                 y,
  input  logic                       valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] read_value,
  input  logic                       read_index,
  input  logic                       connect_en,
  output logic [ADDR_W-1:0]          read_address,
  output logic                       valid_pixel,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int X_END = X_START + (2 ** ADDR_W);
  localparam int Y_LIM = 2 ** (SAMPLE_W + 1);

  logic [10:0]         x_off;
  logic                in_x, in_y;
  logic [IDX_W-1:0]    idx;
  logic [12-ADDR_W:0]  unused_bits;

  logic                disp_half_q, disp_half_d;
  logic                valid_s0_q, valid_s0_d;
  logic                in_x_s0_q, in_x_s0_d;
  logic                in_y_s0_q, in_y_s0_d;
  logic                first_s0_q, first_s0_d;
  logic [SAMPLE_W-1:0] yv_s0_q, yv_s0_d;
  logic [IDX_W-1:0]    idx_s0_q, idx_s0_d;
  logic [IDX_W-1:0]    idx_old_q, idx_old_d;
  logic                valid_pixel_q, valid_pixel_d;
  logic [23:0]         rgb_q, rgb_d;

  logic                load_prev, gate;
  logic [NUM_CH-1:0]   lit;

  // Window decode; each sample spans two columns.
  always_comb begin
    x_off        = x - 11'(X_START);
    in_x         = ({1'b0, x} >= 12'(X_START)) && ({1'b0, x} < 12'(X_END));
    in_y         = ({1'b0, y} < 11'(Y_LIM));
    idx          = x_off[ADDR_W-1:1];
    read_address = in_x ? {disp_half_q, idx} : '0;
  end

  assign unused_bits = {x_off[10:ADDR_W], x_off[0], y[0]};

  // The producer writes read_index; we show the other half, chosen once per
  // frame so a mid-frame swap cannot tear the image.
  always_comb begin
    disp_half_d = disp_half_q;
    if (valid && (x == 11'd0) && (y == 10'd0)) begin
      disp_half_d = ~read_index;
    end
    valid_s0_d = valid;
    in_x_s0_d  = in_x;
    in_y_s0_d  = in_y;
    first_s0_d = (x == 11'(X_START));
    yv_s0_d    = y[SAMPLE_W:1];
    idx_s0_d   = idx;
    idx_old_d  = idx_s0_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_half_q <= 1'b0;
      valid_s0_q  <= 1'b0;
      in_x_s0_q   <= 1'b0;
      in_y_s0_q   <= 1'b0;
      first_s0_q  <= 1'b0;
      yv_s0_q     <= '0;
      idx_s0_q    <= '0;
      idx_old_q   <= '0;
    end else begin
      disp_half_q <= disp_half_d;
      valid_s0_q  <= valid_s0_d;
      in_x_s0_q   <= in_x_s0_d;
      in_y_s0_q   <= in_y_s0_d;
      first_s0_q  <= first_s0_d;
      yv_s0_q     <= yv_s0_d;
      idx_s0_q    <= idx_s0_d;
      idx_old_q   <= idx_old_d;
    end
  end

  assign load_prev = (idx_s0_q != idx_old_q) || first_s0_q;
  assign gate      = valid_s0_q && in_x_s0_q && in_y_s0_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    wave_channel_cmp #(
      .SAMPLE_W(SAMPLE_W)
    ) u_cmp (
      .clk       (clk),
      .reset     (reset),
      .load_prev (load_prev),
      .first     (first_s0_q),
      .cur       (read_value[c*SAMPLE_W +: SAMPLE_W]),
      .yv        (yv_s0_q),
      .gate      (gate),
      .connect_en(connect_en),
      .lit       (lit[c])
    );
  end

  // Walk from the highest channel down so the lowest lit channel wins.
  always_comb begin
    valid_pixel_d = |lit;
    rgb_d         = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (lit[c]) begin
        rgb_d = CH_COLORS[c*24 +: 24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_pixel_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      valid_pixel_q <= valid_pixel_d;
      rgb_q         <= rgb_d;
    end
  end

  assign valid_pixel = valid_pixel_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];

endmodule

// File: tb/tb_multi_wave_display.sv
// tb_multi_wave_display
// Self-checking bench: a behavioural RAM feeds the renderer, each driven
// pixel pushes its expected colour onto a scoreboard queue, and the entry
// is popped two cycles later when that pixel reaches the outputs.
module tb_multi_wave_display;

  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;
  localparam int ADDR_W   = 9;
  localparam int X_START  = 256;

  typedef struct {
    bit          chk;
    logic [24:0] exp;
    string       tag;
  } item_t;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [10:0]                x;
  logic [9:0]                 y;
  logic                       valid;
  logic [NUM_CH*SAMPLE_W-1:0] read_value;
  logic                       read_index;
  logic                       connect_en;
  logic [ADDR_W-1:0]          read_address;
  logic                       valid_pixel;
  logic [7:0]                 r, g, b;

  logic [7:0]  mem [NUM_CH][512];
  logic [23:0] colors [4] = '{24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h00FF00};
  bit          dh;
  item_t       sb[$];
  int          passCount  = 0;
  int          checkCount = 0;

  multi_wave_display #(
    .NUM_CH  (NUM_CH),
    .SAMPLE_W(SAMPLE_W),
    .ADDR_W  (ADDR_W),
    .X_START (X_START)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .valid       (valid),
    .read_value  (read_value),
    .read_index  (read_index),
    .connect_en  (connect_en),
    .read_address(read_address),
    .valid_pixel (valid_pixel),
    .r           (r),
    .g           (g),
    .b           (b)
  );

  always #5 clk = ~clk;

  // Sample RAMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      read_value[c*SAMPLE_W +: SAMPLE_W] <= mem[c][read_address];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int modelAddr(input int px);
    if (px >= X_START && px < X_START + 512) return int'(dh) * 256 + (px - X_START) / 2;
    return 0;
  endfunction

  function automatic logic [24:0] modelPixel(input int px, input int py,
                                             input bit pv, input bit ce);
    int idx, yv, cur, prv, lo, hi;
    bit hit;
    logic [24:0] res;
    res = '0;
    if (!(pv && px >= X_START && px < X_START + 512 && py < 512)) return res;
    idx = (px - X_START) / 2;
    yv  = py / 2;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      cur = int'(mem[c][int'(dh) * 256 + idx]);
      prv = (px - X_START < 2) ? cur : int'(mem[c][int'(dh) * 256 + idx - 1]);
      lo  = (prv < cur) ? prv : cur;
      hi  = (prv < cur) ? cur : prv;
      hit = ce ? (yv >= lo && yv <= hi) : (yv == cur);
      if (hit) res = {1'b1, colors[c]};
    end
    return res;
  endfunction

  // One pixel per clock: retire the pixel driven two cycles ago, then drive
  // the next one and queue its expected result.
  task automatic applyStimulus(input int px, input int py, input bit pv,
                               input bit prst, input bit chk, input string tag);
    item_t it, due;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      due = sb.pop_front();
      if (due.chk) checkOutput(due.tag, {7'b0, valid_pixel, r, g, b}, {7'b0, due.exp});
    end
    x     = 11'(px);
    y     = 10'(py);
    valid = pv;
    reset = prst;
    #1;
    if (chk) checkOutput({tag, "_addr"}, 32'(read_address), 32'(modelAddr(px)));
    it.chk = chk;
    it.tag = tag;
    it.exp = prst ? 25'd0 : modelPixel(px, py, pv, connect_en);
    if (prst) begin
      if (sb.size() > 0) begin
        due = sb.pop_front();
        due.exp = '0;
        sb.push_front(due);
      end
      dh = 1'b0;
    end else if (pv && px == 0 && py == 0) begin
      dh = ~read_index;
    end
    sb.push_back(it);
  endtask

  task automatic scanRow(input int py, input int xa, input int xb, input bit pv,
                         input string tag);
    for (int px = xa; px <= xb; px++) applyStimulus(px, py, pv, 1'b0, 1'b1, tag);
  endtask

  task automatic drain();
    applyStimulus(1279, 1023, 1'b0, 1'b0, 1'b1, "idle");
    applyStimulus(1279, 1023, 1'b0, 1'b0, 1'b1, "idle");
  endtask

  task automatic setChannel(input int c, input int val);
    for (int i = 0; i < 512; i++) mem[c][i] = 8'(val);
  endtask

  initial begin
    reset      = 1'b1;
    x          = '0;
    y          = '0;
    valid      = 1'b0;
    read_index = 1'b0;
    connect_en = 1'b0;
    dh         = 1'b0;
    setChannel(0, 5);
    setChannel(1, 5);

    @(posedge clk);
    #1;
    checkOutput("reset_out", {7'b0, valid_pixel, r, g, b}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(300, 10, 1'b1, 1'b1, 1'b1, "reset");
    drain();

    // Flat samples: full-row scans with and without valid, and off-window rows.
    scanRow(10, 0, 1279, 1'b1, "flat_y10");
    scanRow(10, 240, 780, 1'b0, "flat_novalid");
    scanRow(600, 250, 270, 1'b1, "flat_offy");
    drain();

    // Frame-latched buffer half.
    read_index = 1'b1;
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, "frame0");
    scanRow(20, 290, 310, 1'b1, "frame0_a");
    read_index = 1'b0;
    scanRow(20, 311, 330, 1'b1, "frame0_b");
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1, "frame_novalid");
    scanRow(20, 290, 300, 1'b1, "frame0_c");
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, "frame1");
    scanRow(20, 290, 300, 1'b1, "frame1_a");
    drain();

    // Ramp on ch0, dot mode.
    for (int i = 0; i < 512; i++) mem[0][i] = 8'(i % 256);
    setChannel(1, 200);
    drain();
    foreach (colors[k]) begin end
    scanRow(0, 250, 775, 1'b1, "ramp_k0");
    scanRow(14, 250, 300, 1'b1, "ramp_k7");
    scanRow(200, 440, 470, 1'b1, "ramp_k100");
    scanRow(510, 750, 775, 1'b1, "ramp_k255");
    drain();

    // Connected lines: 10 at idx 3, 20 at idx 4.
    setChannel(0, 30);
    mem[0][3] = 8'd10; mem[0][256 + 3] = 8'd10;
    mem[0][4] = 8'd20; mem[0][256 + 4] = 8'd20;
    drain();
    connect_en = 1'b1;
    for (int py = 16; py <= 44; py++) scanRow(py, 250, 270, 1'b1, "connect");
    scanRow(60, 250, 270, 1'b1, "connect_y60");
    drain();
    connect_en = 1'b0;
    drain();

    // Channel priority.
    setChannel(0, 50);
    setChannel(1, 50);
    drain();
    scanRow(100, 250, 300, 1'b1, "prio_equal");
    drain();
    setChannel(0, 60);
    drain();
    scanRow(100, 250, 300, 1'b1, "prio_ch1");
    scanRow(120, 250, 300, 1'b1, "prio_ch0");
    drain();

    // Reset in mid-frame, then recovery at the next frame start.
    for (int px = 380; px <= 420; px++)
      applyStimulus(px, 100, 1'b1, px == 400, 1'b1, "rst_mid");
    read_index = 1'b0;
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b1, "frame2");
    scanRow(100, 380, 420, 1'b1, "after_rst");
    drain();
    drain();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
